hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core.
- Drives write-enable and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Detects load-use (or full RAW) data hazards, taken branches/jumps, instruction- and data-memory stalls, and halt.
- Sits beside the decode stage; consumes destination/control fields already carried by the pipeline latches.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter
REG_W, 3, register-specifier width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
IDRs  in  REG_W  source reg 1 of instruction in ID
IDRt  in  REG_W  source reg 2 of instruction in ID
IDUsesRs  in  1  ID instruction reads IDRs
IDUsesRt  in  1  ID instruction reads IDRt
IDEX_WriteReg  in  REG_W  dest reg held in ID/EX
IDEX_RegWrite  in  1  ID/EX instruction writes a register
IDEX_MemRead  in  1  ID/EX instruction is a load
EXMEM_WriteReg  in  REG_W  dest reg held in EX/MEM
EXMEM_RegWrite  in  1  EX/MEM writes a register
MEMWB_WriteReg  in  REG_W  dest reg held in MEM/WB
MEMWB_RegWrite  in  1  MEM/WB writes a register
BranchTaken  in  1  taken branch/jump resolved in EX/MEM
DMemEn  in  1  EX/MEM instruction accesses data memory
DMemStall  in  1  data memory not ready
DMemDone  in  1  data memory access complete
IMemStall  in  1  instruction fetch not ready
Halt  in  1  halt/dump instruction in EX/MEM
PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  latch write enables
IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  load a NOP/bubble into that latch
halted  out  1  registered; core stopped
stallCount  out  CNT_W  registered; cycles with PC_en=0

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous, active-high.
- While rst=1: all enables and flushes 0. Next state is RUN; halted=0; stallCount=0.
- FSM states: RUN, DMEM_WAIT, HALTED. The state is registered; enables and flushes are combinational from state and inputs.
- Default in RUN, no event: all enables 1, all flushes 0.
- Priority in RUN (highest first): data-mem stall > Halt > BranchTaken > data hazard > IMemStall.
- Data-mem stall (DMemEn & DMemStall & ~DMemDone):
  - PC/IFID/IDEX/EXMEM enables 0; MEMWB_en=1 with bubble (EX/MEM result must not retire twice).
  - Next state DMEM_WAIT.
- DMEM_WAIT:
  - Same outputs as a data-mem stall while DMemDone=0.
  - Cycle DMemDone=1: all enables 1, next state RUN. Branch/hazard rules apply in the same cycle.
- Halt (RUN, not stalled): all enables 1 this cycle so the dump retires. Next state HALTED.
- HALTED: all enables 0, flushes 0, halted=1. Exit only by rst.
- BranchTaken: all enables 1; IFID_flush=IDEX_flush=EXMEM_flush=1 (three wrong-path instructions squashed).
- Data hazard, load-use:
  - Condition: IDEX_MemRead & IDEX_RegWrite & ((IDUsesRs & IDRs==IDEX_WriteReg) | (IDUsesRt & IDRt==IDEX_WriteReg)).
  - Response: PC_en=IFID_en=0, IDEX_flush=1, others enabled.
- IMemStall: PC_en=0, IFID_flush=1, IFID_en=1; downstream advances.
- BranchTaken together with a hazard: branch wins; the stalled ID instruction is squashed anyway.
- stallCount: +1 on each clock where state≠HALTED, rst=0 and PC_en=0. Saturates at all-ones with no wrap.
- Register 0 is an ordinary register; no special-casing.

Optional Feature:
HAZ_FORWARD_EN
- Defined: forwarding exists; only the load-use hazard stalls.
- Undefined: the data hazard also triggers for any match of an ID source against IDEX_WriteReg, EXMEM_WriteReg or MEMWB_WriteReg whose RegWrite is 1, independent of MemRead. Same stall response; held until no match remains.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_RegWrite=1, IDEX_WriteReg=3, IDRs=3, IDUsesRs=1 -> one cycle PC_en=0, IFID_en=0, IDEX_flush=1; stallCount 0->1. Deassert -> all enables 1.
- No-forward RAW (macro undefined): EXMEM_WriteReg=5, EXMEM_RegWrite=1, IDRt=5, IDUsesRt=1 -> stall. With macro defined -> no stall.
- Data-mem stall: DMemEn=1, DMemStall=1 for 4 cycles, then DMemDone=1 -> 4 cycles PC/IFID/IDEX/EXMEM_en=0 with MEMWB bubble; state DMEM_WAIT; stallCount=4; release on the Done cycle.
- Branch and load-use same cycle: BranchTaken=1 plus hazard -> all enables 1, three flushes 1, no stall count.
- Halt: Halt=1 -> that cycle all enables 1; next cycle halted=1, all enables 0 and held for 10 cycles. rst=1 -> halted=0, stallCount=0.
- Saturation: CNT_W=4, IMemStall=1 for 20 cycles -> stallCount stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall/flush controller for the 5-stage core
// Define HAZ_FORWARD_EN when forwarding exists (only load-use stalls); otherwise any RAW match stalls.
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IDRs,
  input  logic [REG_W-1:0] IDRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic [REG_W-1:0] IDEX_WriteReg,
  input  logic             IDEX_RegWrite,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] EXMEM_WriteReg,
  input  logic             EXMEM_RegWrite,
  input  logic [REG_W-1:0] MEMWB_WriteReg,
  input  logic             MEMWB_RegWrite,
  input  logic             BranchTaken,
  input  logic             DMemEn,
  input  logic             DMemStall,
  input  logic             DMemDone,
  input  logic             IMemStall,
  input  logic             Halt,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             EXMEM_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stallCount
);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, HALTED} state_t;

  state_t     state_q, state_d;
  logic       halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic idex_match, exmem_match, memwb_match;
  logic load_use, data_hazard, dmem_stall;

  assign idex_match  = IDEX_RegWrite  & ((IDUsesRs & (IDRs == IDEX_WriteReg))  | (IDUsesRt & (IDRt == IDEX_WriteReg)));
  assign exmem_match = EXMEM_RegWrite & ((IDUsesRs & (IDRs == EXMEM_WriteReg)) | (IDUsesRt & (IDRt == EXMEM_WriteReg)));
  assign memwb_match = MEMWB_RegWrite & ((IDUsesRs & (IDRs == MEMWB_WriteReg)) | (IDUsesRt & (IDRt == MEMWB_WriteReg)));
  assign load_use    = IDEX_MemRead & idex_match;

`ifdef HAZ_FORWARD_EN
  assign data_hazard = load_use;
`else
  assign data_hazard = idex_match | exmem_match | memwb_match;
`endif

  // Once in DMEM_WAIT the wait is held purely by the absence of DMemDone.
  assign dmem_stall = (state_q == DMEM_WAIT) ? ~DMemDone
                                              : (DMemEn & DMemStall & ~DMemDone);

  always_comb begin
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    MEMWB_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    state_d     = state_q;
    if (rst) begin
      {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = 5'b0;
      state_d = RUN;
    end else if (state_q == HALTED) begin
      {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en} = 5'b0;
    end else if (dmem_stall) begin
      {PC_en, IFID_en, IDEX_en, EXMEM_en} = 4'b0;
      state_d = DMEM_WAIT;
    end else begin
      state_d = RUN;
      if (Halt) begin
        state_d = HALTED;
      end else if (BranchTaken) begin
        IFID_flush  = 1'b1;
        IDEX_flush  = 1'b1;
        EXMEM_flush = 1'b1;
      end else if (data_hazard) begin
        PC_en      = 1'b0;
        IFID_en    = 1'b0;
        IDEX_flush = 1'b1;
      end else if (IMemStall) begin
        PC_en      = 1'b0;
        IFID_flush = 1'b1;
      end
    end
  end

  always_comb begin
    halted_d = (state_d == HALTED);
    cnt_d    = cnt_q;
    if (rst)
      cnt_d = '0;
    else if ((state_q != HALTED) && !PC_en && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign halted     = halted_q;
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl (CNT_W=4)
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int REG_W = 3;
`ifdef HAZ_FORWARD_EN
  localparam int RAW_STALL = 0;
`else
  localparam int RAW_STALL = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] IDRs, IDRt, IDEX_WriteReg, EXMEM_WriteReg, MEMWB_WriteReg;
  logic IDUsesRs, IDUsesRt, IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, MEMWB_RegWrite;
  logic BranchTaken, DMemEn, DMemStall, DMemDone, IMemStall, Halt;
  logic PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
  logic IFID_flush, IDEX_flush, EXMEM_flush, halted;
  logic [CNT_W-1:0] stallCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDEX_WriteReg(IDEX_WriteReg), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .EXMEM_WriteReg(EXMEM_WriteReg), .EXMEM_RegWrite(EXMEM_RegWrite),
    .MEMWB_WriteReg(MEMWB_WriteReg), .MEMWB_RegWrite(MEMWB_RegWrite),
    .BranchTaken(BranchTaken), .DMemEn(DMemEn), .DMemStall(DMemStall), .DMemDone(DMemDone),
    .IMemStall(IMemStall), .Halt(Halt),
    .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
    .halted(halted), .stallCount(stallCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] en, input logic [2:0] fl);
    check({tag, "_en"}, {27'd0, PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en}, {27'd0, en});
    check({tag, "_fl"}, {29'd0, IFID_flush, IDEX_flush, EXMEM_flush}, {29'd0, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IDRs = '0; IDRt = '0; IDUsesRs = 0; IDUsesRt = 0;
    IDEX_WriteReg = '0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
    EXMEM_WriteReg = '0; EXMEM_RegWrite = 0; MEMWB_WriteReg = '0; MEMWB_RegWrite = 0;
    BranchTaken = 0; DMemEn = 0; DMemStall = 0; DMemDone = 0; IMemStall = 0; Halt = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    check_out("reset", 5'b00000, 3'b000);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_cnt", {28'd0, stallCount}, 32'd0);
    rst = 0; #1;
    check_out("run_idle", 5'b11111, 3'b000);

    // load-use on Rs
    IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 3; IDRs = 3; IDUsesRs = 1; #1;
    check_out("load_use", 5'b00111, 3'b010);
    tick(); exp_cnt = 1;
    check("load_use_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs(); #1;
    check_out("load_use_release", 5'b11111, 3'b000);

    // RAW against EX/MEM without a load
    EXMEM_WriteReg = 5; EXMEM_RegWrite = 1; IDRt = 5; IDUsesRt = 1; #1;
    check_out("raw_exmem", RAW_STALL ? 5'b00111 : 5'b11111, RAW_STALL ? 3'b010 : 3'b000);
    tick(); exp_cnt += RAW_STALL;
    check("raw_exmem_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs();

    // register 0 is an ordinary register; unused source never matches
    IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 0; IDRt = 0; IDUsesRt = 1; IDRs = 0; #1;
    check_out("reg0_load_use", 5'b00111, 3'b010);
    IDUsesRt = 0; #1;
    check_out("unused_src", 5'b11111, 3'b000);
    IDUsesRt = 1; tick(); exp_cnt += 1;
    check("reg0_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs();

    // data-memory stall: 4 stalled cycles, DMEM_WAIT holds without DMemStall
    DMemEn = 1; DMemStall = 1; #1;
    for (int i = 0; i < 4; i++) begin
      check_out("dmem_stall", 5'b00001, 3'b000);
      tick();
      DMemStall = 0; #1;
    end
    exp_cnt += 4;
    check("dmem_cnt", {28'd0, stallCount}, exp_cnt);
    DMemDone = 1; #1;
    check_out("dmem_done", 5'b11111, 3'b000);
    tick();
    check("dmem_done_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs(); #1;
    check_out("dmem_after", 5'b11111, 3'b000);

    // branch beats load-use hazard
    BranchTaken = 1; IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_WriteReg = 2; IDRs = 2; IDUsesRs = 1; #1;
    check_out("branch_hazard", 5'b11111, 3'b111);
    tick();
    check("branch_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs();

    // instruction-memory stall
    IMemStall = 1; #1;
    check_out("imem_stall", 5'b01111, 3'b100);
    tick(); exp_cnt += 1;
    check("imem_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs();

    // data-memory stall beats halt
    DMemEn = 1; DMemStall = 1; Halt = 1; #1;
    check_out("dmem_over_halt", 5'b00001, 3'b000);
    tick(); exp_cnt += 1;
    check("dmem_over_halt_halted", {31'd0, halted}, 32'd0);
    DMemStall = 0; DMemDone = 1; Halt = 0; #1;
    check_out("dmem_over_halt_done", 5'b11111, 3'b000);
    tick();
    check("dmem_over_halt_cnt", {28'd0, stallCount}, exp_cnt);
    clear_inputs();

    // halt: dump retires, then frozen until reset
    Halt = 1; #1;
    check_out("halt_cycle", 5'b11111, 3'b000);
    tick(); Halt = 0; #1;
    for (int i = 0; i < 10; i++) begin
      check_out("halted_hold", 5'b00000, 3'b000);
      check("halted_flag", {31'd0, halted}, 32'd1);
      tick();
    end
    check("halted_cnt", {28'd0, stallCount}, exp_cnt);
    rst = 1; tick();
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", {28'd0, stallCount}, 32'd0);
    rst = 0; #1;
    check_out("rst_run", 5'b11111, 3'b000);

    // saturation at 15
    IMemStall = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13 || i == 14 || i == 19)
        check("sat_cnt", {28'd0, stallCount}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    clear_inputs(); #1;
    check_out("sat_release", 5'b11111, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
